// File: rtl/candy_pkg.sv
// Shared definitions for the candy vending coin interface: coin codes,
// change-dispenser state encoding and a small sizing helper.
package candy_pkg;

    // Two-bit coin codes, common to the vending FSM and the change dispenser
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    // Change dispenser state encoding
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_GAP  = 3'd3,
        ST_FIN  = 3'd4,
        ST_JAM  = 3'd5
    } state_e;

    // Larger of two sizes; the shared timer must hold both wait lengths
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/candy_change_timer.sv
// Loadable down-counter with a zero flag. Used by the change dispenser for
// both the inter-coin gap and the hopper acknowledge timeout.
module candy_change_timer
    import candy_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    // Load takes priority; otherwise count down while enabled, saturating at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/candy_change.sv
// Change/refund dispenser. On a vend it returns credit - PRICE, on a cancel the
// full credit, one coin per hopper handshake, largest coin first. A missing
// acknowledge latches a sticky jam that only reset clears.
module candy_change
    import candy_pkg::*;
#(
    parameter int unsigned PRICE    = 3,
    parameter int unsigned CREDIT_W = 3,
    parameter int unsigned GAP_CYC  = 2,
    parameter int unsigned ACK_TO   = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                vend_req,
    input  logic                cancel_req,
    input  logic [CREDIT_W-1:0] credit,
    output logic [1:0]          coin_out,
    output logic                coin_valid,
    input  logic                coin_ack,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                jam
);

    // One counter serves both waits, so size it for the longer one
    localparam int unsigned TW = $clog2(max_u(ACK_TO, GAP_CYC) + 1);

    // Timer reload values: the counter is checked for zero at the end of the
    // last cycle, so an N-cycle wait loads N-1
    localparam logic [TW-1:0] ACK_LOAD = TW'((ACK_TO > 0) ? ACK_TO - 1 : 0);
    localparam logic [TW-1:0] GAP_LOAD = TW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    localparam logic [CREDIT_W-1:0] PRICE_V = CREDIT_W'(PRICE);

    // Registered state and outputs
    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] rem_q, rem_d;
    logic [1:0]          coin_out_q, coin_out_d;
    logic                coin_valid_q, coin_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                jam_q, jam_d;

    // Shared coin decision (LOAD, end of GAP, or straight after an ack with no gap)
    logic                decide;
    logic [CREDIT_W-1:0] decide_rem;
    logic [CREDIT_W-1:0] rem_after_ack;

    // Timer interface
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_en;
    logic          tmr_zero;

    candy_change_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    // Timer counts only while a coin is outstanding or a gap is running
    assign tmr_en = (state_q == ST_SEND) || (state_q == ST_GAP);

    // Remaining credit once the coin currently presented is accepted
    assign rem_after_ack = rem_q - ((coin_out_q == COIN_10) ? CREDIT_W'(2) : CREDIT_W'(1));

    // Next-state, next-output and timer control decisions
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        coin_out_d   = coin_out_q;
        coin_valid_d = coin_valid_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        jam_d        = jam_q;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        decide       = 1'b0;
        decide_rem   = '0;

        case (state_q)
            ST_IDLE: begin
                // Cancel beats vend when both arrive together
                if (cancel_req) begin
                    rem_d   = credit;
                    state_d = ST_LOAD;
                end else if (vend_req) begin
                    if (credit >= PRICE_V) begin
                        rem_d   = credit - PRICE_V;
                        state_d = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                decide     = 1'b1;
                decide_rem = rem_q;
            end

            ST_SEND: begin
                // An ack wins over a timeout landing in the same cycle
                if (coin_ack) begin
                    rem_d        = rem_after_ack;
                    coin_valid_d = 1'b0;
                    coin_out_d   = COIN_NONE;
                    if (GAP_CYC == 0) begin
                        decide     = 1'b1;
                        decide_rem = rem_after_ack;
                    end else begin
                        state_d  = ST_GAP;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LOAD;
                    end
                end else if (tmr_zero) begin
                    coin_valid_d = 1'b0;
                    coin_out_d   = COIN_NONE;
                    jam_d        = 1'b1;
                    state_d      = ST_JAM;
                end
            end

            ST_GAP: begin
                if (tmr_zero) begin
                    decide     = 1'b1;
                    decide_rem = rem_q;
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            ST_JAM: begin
                state_d = ST_JAM;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Greedy coin selection: tens while at least 2 steps remain
        if (decide) begin
            if (decide_rem == '0) begin
                state_d      = ST_FIN;
                done_d       = 1'b1;
                coin_valid_d = 1'b0;
                coin_out_d   = COIN_NONE;
            end else begin
                state_d      = ST_SEND;
                coin_valid_d = 1'b1;
                coin_out_d   = (decide_rem >= CREDIT_W'(2)) ? COIN_10 : COIN_5;
                tmr_load     = 1'b1;
                tmr_val      = ACK_LOAD;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset aborts any sequence immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            coin_out_q   <= COIN_NONE;
            coin_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            jam_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            coin_out_q   <= coin_out_d;
            coin_valid_q <= coin_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            jam_q        <= jam_d;
        end
    end

    assign coin_out   = coin_out_q;
    assign coin_valid = coin_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign jam        = jam_q;

endmodule
